// File: rtl/cpu_ppu_bridge.sv
// Master-clock divider producing CPU/PPU enable strobes, a PPU phase counter,
// and a 2-entry FIFO that carries CPU register writes into the PPU timing grid.
module cpu_ppu_bridge #(
    parameter int CPU_DIV = 12,
    parameter int PPU_DIV = 4
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       run,
    output logic       cpu_ce,
    output logic       ppu_ce,
    output logic [1:0] ppu_phase,
    input  logic       cpu_wr_valid,
    input  logic [2:0] cpu_wr_addr,
    input  logic [7:0] cpu_wr_data,
    output logic       cpu_wr_ready,
    output logic       ppu_wr_valid,
    output logic [2:0] ppu_wr_addr,
    output logic [7:0] ppu_wr_data,
    input  logic       ppu_wr_ack,
    output logic       overflow
);
    localparam int CW = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
    localparam int PW = (PPU_DIV > 1) ? $clog2(PPU_DIV) : 1;
    localparam logic [CW-1:0] CPU_MAX = CW'(CPU_DIV - 1);
    localparam logic [PW-1:0] PPU_MAX = PW'(PPU_DIV - 1);

    logic [CW-1:0] cpu_cnt;
    logic [PW-1:0] ppu_cnt;
    logic [10:0]   mem [2];
    logic          head;
    logic          tail;
    logic [1:0]    count;
    logic          push;
    logic          pop;
    logic          drop;

    // Strobes decode registered counters but are gated by run directly, so
    // freezing in a strobe cycle suppresses that strobe immediately.
    assign cpu_ce = run && (cpu_cnt == CPU_MAX);
    assign ppu_ce = run && (ppu_cnt == PPU_MAX);

    assign cpu_wr_ready = (count != 2'd2);
    assign ppu_wr_valid = (count != 2'd0);
    assign ppu_wr_addr  = mem[head][10:8];
    assign ppu_wr_data  = mem[head][7:0];

    assign push = cpu_ce && cpu_wr_valid && cpu_wr_ready;
    assign drop = cpu_ce && cpu_wr_valid && !cpu_wr_ready;
    assign pop  = ppu_ce && ppu_wr_valid && ppu_wr_ack;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cpu_cnt   <= '0;
            ppu_cnt   <= '0;
            ppu_phase <= 2'd0;
        end else if (run) begin
            cpu_cnt <= (cpu_cnt == CPU_MAX) ? '0 : cpu_cnt + CW'(1);
            ppu_cnt <= (ppu_cnt == PPU_MAX) ? '0 : ppu_cnt + PW'(1);
            if (cpu_ce) begin
                ppu_phase <= 2'd0;
            end else if (ppu_ce) begin
                ppu_phase <= ppu_phase + 2'd1;
            end
        end
    end

    // NOTE: the storage is reset as well, so the head outputs read as zero
    // after reset instead of exposing stale data.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            head     <= 1'b0;
            tail     <= 1'b0;
            count    <= 2'd0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[tail] <= {cpu_wr_addr, cpu_wr_data};
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: doc/cpu_ppu_bridge.md
# cpu_ppu_bridge

Derives CPU and PPU clock-enable strobes from the master clock and carries CPU register writes into the PPU timing grid through a 2-entry FIFO. It sits between the CPU core and the PPU register file. Both cores run on the master clock and gate their logic with the enables this block produces. The block also reports which PPU dot within the current CPU cycle is active, for sprite-DMA and NMI alignment.

## Interface
Parameters:
- CPU_DIV, 12, master cycles per CPU tick
- PPU_DIV, 4, master cycles per PPU tick. CPU_DIV must be a multiple of PPU_DIV, with ratio R = CPU_DIV/PPU_DIV in 2..4.

Ports:
- clk_in  input  1  master clock. All logic is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset
- run  input  1  high lets the dividers count; low freezes them
- cpu_ce  output  1  one-master-cycle CPU enable strobe
- ppu_ce  output  1  one-master-cycle PPU enable strobe
- ppu_phase  output  2  PPU ticks since the last cpu_ce, range 0..R-1
- cpu_wr_valid  input  1  CPU write request
- cpu_wr_addr  input  3  PPU register index
- cpu_wr_data  input  8  write data
- cpu_wr_ready  output  1  FIFO can accept a write
- ppu_wr_valid  output  1  FIFO head is valid
- ppu_wr_addr  output  3  head register index
- ppu_wr_data  output  8  head data
- ppu_wr_ack  input  1  PPU consumes the head
- overflow  output  1  sticky flag: a write was dropped

## Operation
Dividers:
- cpu_cnt counts 0..CPU_DIV-1 and ppu_cnt counts 0..PPU_DIV-1.
- Each counter increments on every edge while run=1 and wraps to 0.
- Both counters hold while run=0.
- cpu_ce = run && cpu_cnt==CPU_DIV-1. ppu_ce = run && ppu_cnt==PPU_DIV-1. Both are decodes of registered state.
- The counters start aligned, so cpu_ce always coincides with every R-th ppu_ce.

Phase:
- ppu_phase becomes 0 on an edge where cpu_ce=1.
- Otherwise it increments on an edge where ppu_ce=1.
- Otherwise it holds.

FIFO (depth 2, head/tail pointers plus count 0..2):
- Push: on an edge where cpu_ce && cpu_wr_valid && cpu_wr_ready. The entry stored is {cpu_wr_addr, cpu_wr_data}.
- cpu_wr_ready = count<2, taken from the registered count. A pop in the same cycle does not make room for a push in that cycle.
- Pop: on an edge where ppu_ce && ppu_wr_valid && ppu_wr_ack.
- ppu_wr_valid = count>0. ppu_wr_addr and ppu_wr_data show the head entry.
- Simultaneous push and pop with count=1: count stays 1, the head advances, and the new entry lands at the tail.
- Order is strictly first in, first out.
- Drop: if cpu_ce && cpu_wr_valid && !cpu_wr_ready on an edge, the write is discarded and overflow is set to 1.
- overflow is cleared only by reset.
- Request inputs are ignored on edges where cpu_ce=0, and ppu_wr_ack is ignored on edges where ppu_ce=0.

Reset (rst_n=0, asynchronous):
- cpu_cnt, ppu_cnt, ppu_phase, the pointers, count and overflow all go to 0.
- Resulting outputs: cpu_ce=0, ppu_ce=0, ppu_phase=0, cpu_wr_ready=1, ppu_wr_valid=0, overflow=0. ppu_wr_addr and ppu_wr_data are 0 because the storage is reset.
- Reset mid-transfer discards every queued write.

## Timing
- Cycle numbering: cycle n is the interval after the n-th rising edge following rst_n deassertion, with run=1 throughout.
- ppu_ce is high in cycles 3, 7, 11, 15, ...
- cpu_ce is high in cycles 11, 23, ...
- ppu_phase is 0 in cycles 0..3, 1 in 4..7 and 2 in 8..11. It returns to 0 at cycle 12.
- Push-to-visible latency: 1 edge. A write accepted at the end of cycle 11 gives ppu_wr_valid=1 in cycle 12.
- The earliest pop of that write is at the end of cycle 15.
- Freezing: deasserting run in a strobe cycle kills the strobe combinationally in that same cycle. No edge counts until run returns.
- Throughput: at most 1 push per CPU tick and 1 pop per PPU tick.

## Test plan
- Reset release with run=1 for 48 cycles -> ppu_ce in cycles 3,7,...,47 and cpu_ce in cycles 11,23,35,47; ppu_phase follows 0,1,2 each CPU tick; all other outputs keep their reset values.
- Single write of addr=3, data=0xA5 held across cycle 11 with ppu_wr_ack=1 -> ppu_wr_valid rises in cycle 12 with addr 3, data 0xA5; pop at the end of cycle 15; ppu_wr_valid=0 in cycle 16.
- ppu_wr_ack=0 with writes 0x11, 0x22, 0x33 on three consecutive CPU ticks -> the first two are queued; cpu_wr_ready=0 after the second; the third is dropped and overflow=1 stays set; with ack then raised, the PPU sees 0x11 and then 0x22.
- count=1 with a push and a pop on the same edge (cycle 23, with cpu_ce and ppu_ce both high) -> count stays 1 and the new head is the pushed entry.
- run held low for cycles 5..9 -> no strobes during that window; the strobe schedule shifts by 5 (next ppu_ce at cycle 12); ppu_phase holds its value.
- rst_n pulsed low mid-cycle with 2 entries queued and overflow=1 -> all outputs return to their reset values immediately, without waiting for a clock edge.
